// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding select, scoreboard entry and zero-register types
package hazard_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;
  localparam logic [4:0] XZR_IDX = 5'd31;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       flag_up;
  } sb_entry_t;
  function automatic fwd_sel_t fwd_pick(logic use_src, logic [2:0] hit);
    return !use_src ? FWD_RF : hit[0] ? FWD_EX : hit[1] ? FWD_MEM : hit[2] ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: one scoreboard entry against one source register index
module hazard_match import hazard_pkg::*; #(
  parameter logic [4:0] XZR = XZR_IDX
) (
  input  logic       valid,
  input  logic       reg_write,
  input  logic [4:0] rd,
  input  logic [4:0] src,
  output logic       match
);
  assign match = valid & reg_write & (rd == src) & (src != XZR);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall and branch flush control for a 5-stage pipeline
module hazard_ctrl import hazard_pkg::*; #(
  parameter logic [4:0] XZR = XZR_IDX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rb,
  input  logic        id_use_a,
  input  logic        id_use_b,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_flag_up,
  input  logic        id_cond_br,
  input  logic        id_br_taken,
  output fwd_sel_t    fwd_a,
  output fwd_sel_t    fwd_b,
  output logic        flag_fwd,
  output logic        stall,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [15:0] stall_cnt
);
  sb_entry_t sb [3];
  sb_entry_t id_entry;
  logic [2:0] hit_a, hit_b;
  logic unused_fields;
  assign unused_fields = ^{sb[1].mem_read, sb[1].flag_up, sb[2].mem_read, sb[2].flag_up};
  for (genvar i = 0; i < 3; i++) begin : g_match
    hazard_match #(.XZR(XZR)) u_a (
      .valid(sb[i].valid), .reg_write(sb[i].reg_write), .rd(sb[i].rd), .src(id_rn), .match(hit_a[i])
    );
    hazard_match #(.XZR(XZR)) u_b (
      .valid(sb[i].valid), .reg_write(sb[i].reg_write), .rd(sb[i].rd), .src(id_rb), .match(hit_b[i])
    );
  end
  always_comb begin
    id_entry    = '{id_valid, id_rd, id_reg_write, id_mem_read, id_flag_up};
    fwd_a       = fwd_pick(id_use_a, hit_a);
    fwd_b       = fwd_pick(id_use_b, hit_b);
    stall       = id_valid & sb[0].valid & sb[0].mem_read & ((id_use_a & hit_a[0]) | (id_use_b & hit_b[0]));
    flag_fwd    = id_cond_br & sb[0].valid & sb[0].flag_up;
    pc_we       = ~stall;
    ifid_we     = ~stall;
    idex_bubble = stall;
    ifid_flush  = id_br_taken & id_valid & ~stall;
  end
  // a stalled decode leaves a bubble in EX while older entries keep draining
  always_ff @(posedge clk) begin
    if (reset) begin
      sb        <= '{default: '0};
      stall_cnt <= '0;
    end else begin
      sb[0]     <= stall ? '0 : id_entry;
      sb[1]     <= sb[0];
      sb[2]     <= sb[1];
      stall_cnt <= stall_cnt + 16'(stall & ~&stall_cnt);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl against an instruction-history model
module tb_hazard_ctrl;
  import hazard_pkg::*;
  logic clk = 0, reset = 1;
  logic id_valid, id_use_a, id_use_b, id_reg_write, id_mem_read, id_flag_up, id_cond_br, id_br_taken;
  logic [4:0] id_rn, id_rb, id_rd;
  fwd_sel_t fwd_a, fwd_b;
  logic flag_fwd, stall, pc_we, ifid_we, ifid_flush, idex_bubble;
  logic [15:0] stall_cnt;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rb(id_rb),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_flag_up(id_flag_up), .id_cond_br(id_cond_br),
    .id_br_taken(id_br_taken), .fwd_a(fwd_a), .fwd_b(fwd_b), .flag_fwd(flag_fwd),
    .stall(stall), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stall_cnt(stall_cnt)
  );
  typedef struct {bit v; bit [4:0] rd, rn, rb; bit ua, ub, rw, mr, fu, cb, bt;} ins_t;
  typedef struct {logic [1:0] fa, fb; logic ff, st, fl; logic [15:0] cnt;} exp_t;
  ins_t hist[$];
  exp_t exp_q[$];
  ins_t nop = '{default: 0};
  int model_cnt = 0;
  int n_checks = 0, n_fail = 0;
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask
  function automatic ins_t mk(bit [4:0] rd, rn, rb, bit ua, ub, rw, mr, fu, cb, bt);
    ins_t t = '{1'b1, rd, rn, rb, ua, ub, rw, mr, fu, cb, bt};
    return t;
  endfunction
  // age of the youngest older instruction writing s: 1 = EX, 2 = MEM, 3 = WB, 0 = none
  function automatic logic [1:0] age_fwd(bit u, bit [4:0] s);
    if (!u || s == 5'd31) return 2'd0;
    foreach (hist[i]) if (hist[i].v && hist[i].rw && hist[i].rd == s) return 2'(i + 1);
    return 2'd0;
  endfunction
  task automatic issue(input ins_t in, input bit rst);
    exp_t e;
    @(negedge clk);
    reset = rst;
    id_valid = in.v; id_rd = in.rd; id_rn = in.rn; id_rb = in.rb;
    id_use_a = in.ua; id_use_b = in.ub; id_reg_write = in.rw; id_mem_read = in.mr;
    id_flag_up = in.fu; id_cond_br = in.cb; id_br_taken = in.bt;
    e.fa = age_fwd(in.ua, in.rn);
    e.fb = age_fwd(in.ub, in.rb);
    e.st = in.v && hist.size() > 0 && hist[0].mr && (e.fa == 2'd1 || e.fb == 2'd1);
    e.ff = in.cb && hist.size() > 0 && hist[0].v && hist[0].fu;
    e.fl = in.bt && in.v && !e.st;
    e.cnt = 16'(model_cnt);
    exp_q.push_back(e);
    if (rst) begin
      hist.delete();
      model_cnt = 0;
    end else begin
      if (e.st && model_cnt < 65535) model_cnt++;
      hist.push_front(e.st ? nop : in);
      if (hist.size() > 3) void'(hist.pop_back());
    end
  endtask
  function automatic bit [4:0] rnd_reg();
    return ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd_a", {14'b0, fwd_a}, {14'b0, e.fa});
        check("fwd_b", {14'b0, fwd_b}, {14'b0, e.fb});
        check("flag_fwd", {15'b0, flag_fwd}, {15'b0, e.ff});
        check("stall", {15'b0, stall}, {15'b0, e.st});
        check("pc_we", {15'b0, pc_we}, {15'b0, !e.st});
        check("ifid_we", {15'b0, ifid_we}, {15'b0, !e.st});
        check("idex_bubble", {15'b0, idex_bubble}, {15'b0, e.st});
        check("ifid_flush", {15'b0, ifid_flush}, {15'b0, e.fl});
        check("stall_cnt", stall_cnt, e.cnt);
      end
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    ins_t r, lds;
    {id_valid, id_use_a, id_use_b, id_reg_write, id_mem_read, id_flag_up, id_cond_br, id_br_taken} = '0;
    {id_rn, id_rb, id_rd} = '0;
    repeat (2) @(posedge clk);
    repeat (2) issue(nop, 1);
    // back-to-back, one-gap and two-gap forwarding of X1
    issue(mk(1, 2, 3, 1, 1, 1, 0, 0, 0, 0), 0);
    issue(mk(2, 1, 3, 1, 1, 1, 0, 0, 0, 0), 0);
    issue(mk(1, 2, 3, 1, 1, 1, 0, 0, 0, 0), 0);
    issue(mk(9, 10, 11, 1, 1, 1, 0, 0, 0, 0), 0);
    issue(mk(2, 1, 3, 1, 1, 1, 0, 0, 0, 0), 0);
    issue(mk(1, 2, 3, 1, 1, 1, 0, 0, 0, 0), 0);
    issue(nop, 0);
    issue(nop, 0);
    issue(mk(2, 1, 3, 1, 1, 1, 0, 0, 0, 0), 0);
    // load-use stall, held decode re-presented
    issue(mk(4, 10, 0, 1, 0, 1, 1, 0, 0, 0), 0);
    repeat (2) issue(mk(5, 4, 6, 1, 1, 1, 0, 0, 0, 0), 0);
    // zero register never forwarded or stalled on
    issue(mk(31, 2, 3, 1, 1, 1, 0, 0, 0, 0), 0);
    issue(mk(6, 31, 31, 1, 1, 1, 0, 0, 0, 0), 0);
    issue(mk(31, 10, 0, 1, 0, 1, 1, 0, 0, 0), 0);
    issue(mk(6, 31, 31, 1, 1, 1, 0, 0, 0, 0), 0);
    // flag forwarding to B.cond
    issue(mk(8, 2, 3, 1, 1, 1, 0, 1, 0, 0), 0);
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 0);
    issue(mk(8, 2, 3, 1, 1, 1, 0, 1, 0, 0), 0);
    issue(nop, 0);
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 0);
    // taken CBZ behind a load: stall first, flush once unstalled
    issue(mk(7, 10, 0, 1, 0, 1, 1, 0, 0, 0), 0);
    repeat (2) issue(mk(0, 7, 0, 1, 0, 0, 0, 0, 0, 1), 0);
    // mid-operation reset with X1 writers in every stage
    repeat (3) issue(mk(1, 2, 3, 1, 1, 1, 0, 0, 0, 0), 0);
    issue(nop, 1);
    issue(mk(2, 1, 1, 1, 1, 1, 0, 0, 0, 0), 0);
    // randomized traffic with occasional resets
    repeat (3000) begin
      r = nop;
      if ($urandom_range(0, 4) != 0) begin
        r = mk(rnd_reg(), rnd_reg(), rnd_reg(), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
               1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        r.mr = r.rw && $urandom_range(0, 2) == 0;
      end
      issue(r, $urandom_range(0, 199) == 0);
    end
    // saturation: a self-dependent load stalls every other cycle
    issue(nop, 1);
    lds = mk(4, 4, 0, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2 * 65540 + 1; i++) issue(lds, 0);
    issue(nop, 0);
    issue(nop, 0);
    @(negedge clk);
    #3;
    check("stall_cnt_saturated", stall_cnt, 16'hFFFF);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
